div_ctrl: RTL

Sequencing controller between the EX stage and the multi-cycle divider unit (div).
- Accepts DIV/DIVU operations from EX and latches their operands.
- Drives the divider start/cancel handshake and raises a stall request to the pipeline control block until the quotient/remainder is available.
- Holds the 64-bit result for the HI/LO write until EX advances; on pipeline flush it cancels and drains the divider cleanly.

---
 rtl/div_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU operations through the multi-cycle divider, stalls EX until the result
// is ready, holds it for the HI/LO write and cancels/drains the divider on flush.
module div_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid_input,
  input  logic        op_signed_input,
  input  logic [31:0] op_data1_input,
  input  logic [31:0] op_data2_input,
  input  logic        flush_input,
  input  logic        ex_advance_input,
  output logic        stall_request_output,
  output logic        result_valid_output,
  output logic [63:0] result_output,
  output logic        div_by_zero_output,
  output logic        div_start_output,
  output logic        div_cancel_output,
  output logic        div_signed_output,
  output logic [31:0] div_data1_output,
  output logic [31:0] div_data2_output,
  input  logic [63:0] div_result_input,
  input  logic        div_ready_input
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic start_n, cancel_n, signed_n, valid_n, dbz_n;
  logic [31:0] data1_n, data2_n;
  logic [63:0] result_n;
  assign stall_request_output = (state == IDLE && op_valid_input && !flush_input) ||
                                (state == BUSY && !(div_ready_input && !flush_input)) ||
                                (state == DRAIN && op_valid_input);
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    start_n  = div_start_output;
    cancel_n = div_cancel_output;
    signed_n = div_signed_output;
    data1_n  = div_data1_output;
    data2_n  = div_data2_output;
    result_n = result_output;
    valid_n  = result_valid_output;
    dbz_n    = div_by_zero_output;
    case (state)
      IDLE: if (op_valid_input && !flush_input) begin
        start_n  = 1'b1;
        signed_n = op_signed_input;
        data1_n  = op_data1_input;
        data2_n  = op_data2_input;
        state_n  = BUSY;
      end
      BUSY: if (flush_input) begin
        start_n  = 1'b0;
        cancel_n = 1'b1;
        cnt_n    = CW'(DRAIN_CYCLES - 1);
        state_n  = DRAIN;
      end else if (div_ready_input) begin
        result_n = div_result_input;
        dbz_n    = div_data2_output == 32'd0;
        valid_n  = 1'b1;
        state_n  = DONE;
      end
      DONE: if (flush_input || ex_advance_input) begin
        valid_n = 1'b0;
        start_n = 1'b0;
        state_n = IDLE;
      end
      DRAIN: if (cnt == '0) begin
        cancel_n = 1'b0;
        state_n  = IDLE;
      end else cnt_n = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      div_start_output    <= 1'b0;
      div_cancel_output   <= 1'b0;
      div_signed_output   <= 1'b0;
      div_data1_output    <= '0;
      div_data2_output    <= '0;
      result_output       <= '0;
      result_valid_output <= 1'b0;
      div_by_zero_output  <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      div_start_output    <= start_n;
      div_cancel_output   <= cancel_n;
      div_signed_output   <= signed_n;
      div_data1_output    <= data1_n;
      div_data2_output    <= data2_n;
      result_output       <= result_n;
      result_valid_output <= valid_n;
      div_by_zero_output  <= dbz_n;
    end
  end
endmodule
